axi_full_slave_mem: RTL
=======================

Name: axi_full_slave_mem

Overview:
- AXI4-Full slave memory responder: the other end of the DMA's read master (M00) and write master (M01).
- Serves INCR and FIXED bursts from an internal word-addressed RAM.
- Used as the DMA's source/destination target in system simulation and as on-chip scratch RAM on the Basys3 build.
- Read and write channels are independent; each accepts one outstanding burst.

Parameters:
C_S_AXI_ID_WIDTH, 1, AXI ID width
C_S_AXI_ADDR_WIDTH, 32, byte address width
C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32 (4-byte beats)
C_BASE_ADDR, 32'h40000000, byte address of word 0
C_MEM_DEPTH, 1024, RAM depth in 32-bit words (power of two)

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESET  in  1  reset, synchronous, active-high
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address
S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1
S_AXI_WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write data;  S_AXI_WREADY  out  1
S_AXI_BID/BRESP/BVALID  out  ID/2/1  write response;  S_AXI_BREADY  in  1
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address
S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1
S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/32/2/1/1  read data;  S_AXI_RREADY  in  1

Behaviour:
- One clock (S_AXI_ACLK); reset S_AXI_ARESET is synchronous and active-high.
- Reset:
  - All outputs are 0: AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RLAST, RRESP, RID, RDATA.
  - Both FSMs go to IDLE, including mid-burst.
  - RAM contents are retained, not cleared.
  - AWREADY and ARREADY rise the first cycle after reset is released.
- Address decode:
  - index = (addr - C_BASE_ADDR) >> 2; addr[1:0] is ignored.
  - A beat is in range iff C_BASE_ADDR <= addr < C_BASE_ADDR + 4*C_MEM_DEPTH.
  - INCR: addr += 4 per beat. FIXED (2'b00): addr is constant.
  - WRAP/reserved burst types, or SIZE != 3'b010: the burst is executed as INCR and its response is SLVERR.
  - No 4KB-boundary check.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len and clear the beat counter; AWREADY falls next cycle.
  - W_DATA: WREADY=1. Each W handshake writes the in-range word with byte-lane WSTRB masking, then advances the address and counter.
  - W_DATA exit: the beat with counter == AWLEN ends the burst, independent of WLAST.
  - WLAST mismatch (WLAST=1 before the last beat, or 0 on it) sets a sticky error.
  - Any out-of-range beat also sets the sticky error; that beat is dropped.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 if the sticky error is set, else 2'b00. Hold until BREADY, then W_IDLE next cycle.
  - Minimum AW-handshake to BVALID: AWLEN+2 cycles with WVALID held high.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, latch ID/addr/len.
  - First beat: RVALID rises the next cycle, with RDATA registered from the RAM (array read combinationally into the output register).
  - Beat advance: on each R handshake, load the next beat in the same edge. Back-to-back beats every cycle while RREADY=1, so burst length = ARLEN+1 cycles.
  - Backpressure: RVALID && !RREADY holds RDATA/RRESP/RLAST/RID stable.
  - RLAST=1 only on beat ARLEN.
  - Out-of-range beat: RDATA=0, RRESP=2'b10. Otherwise RRESP=2'b00 (or SLVERR for an illegal burst/size).
  - After the RLAST handshake, go to R_IDLE; ARREADY=1 the following cycle.
- Simultaneous read and write to the same word: the read register loads pre-write data; the write commits at the same edge.
- AW and AR may handshake in the same cycle; the channels never block each other.

Test Plan:
1. Reset 3 cycles, then AW 0x40000000 len=15 INCR, 16 beats 0xA0..0xAF with WLAST on beat 15 -> BVALID with BRESP=00, BID=0; AR same address len=15 -> 16 beats 0xA0..0xAF, RLAST on beat 15 only, first RVALID 1 cycle after AR handshake.
2. Read len=7 with RREADY toggled 1,0,0,1 repeating -> data stable while stalled, 8 beats in order, no beat lost or duplicated.
3. Write len=0 at 0x40000004, data 0x11223344 strb=4'b0101 over prior 0xFFFFFFFF -> read returns 0xFF22FF44.
4. Write len=3 at 0x40000FF8 with C_MEM_DEPTH=1024 -> beats 2-3 dropped, BRESP=10; read of 0x40000FF8 len=3 -> RRESP 00,00,10,10 with RDATA 0 on beats 2-3.
5. WLAST asserted on beat 1 of a len=3 burst -> 4 beats accepted, BRESP=10; FIXED burst len=3 -> only the last beat's data remains at the address.
6. Assert reset mid read burst (beat 3 of 8) -> RVALID=0 next cycle, ARREADY=1 after release, RAM contents intact on re-read.

Source files
------------

// File: rtl/axi_full_slave_mem.sv
// AXI4-Full slave memory: independent read/write burst engines (INCR/FIXED) over a word-addressed RAM.
// Each channel accepts one outstanding burst; illegal burst types or sizes run as INCR and answer SLVERR.
`timescale 1ns/1ps
module axi_full_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h40000000,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(C_MEM_DEPTH);
    localparam logic [AW-1:0] MEM_BYTES = AW'(4 * C_MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    // Comparing the offset rather than an end address keeps the test safe near the top of the address space.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return (addr >= C_BASE_ADDR) && ((addr - C_BASE_ADDR) < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [AW-1:0] addr);
        return IDX_W'((addr - C_BASE_ADDR) >> 2);
    endfunction

    function automatic logic illegal_burst(input logic [1:0] burst, input logic [2:0] size);
        return !(((burst == 2'b00) || (burst == 2'b01)) && (size == 3'b010));
    endfunction

    function automatic logic fixed_burst(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b00) && (size == 3'b010);
    endfunction

    function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] addr, input logic fixed);
        return fixed ? addr : addr + AW'(4);
    endfunction

    // Write channel state
    w_state_t                    w_state_reg, w_state_next;
    logic                        awready_reg;
    logic [C_S_AXI_ID_WIDTH-1:0] aw_id_reg;
    logic [AW-1:0]               aw_addr_reg;
    logic [7:0]                  aw_len_reg, w_cnt_reg;
    logic                        aw_fixed_reg, w_err_reg;
    logic                        aw_hs, w_hs, w_last_beat, wr_ok, wr_en;
    logic [IDX_W-1:0]            wr_idx;

    // Read channel state
    r_state_t                    r_state_reg, r_state_next;
    logic                        arready_reg, rvalid_reg, rlast_reg;
    logic [1:0]                  rresp_reg;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg, rd_word;
    logic [AW-1:0]               ar_addr_reg, rd_addr;
    logic [7:0]                  ar_len_reg, r_cnt_reg;
    logic                        ar_fixed_reg, ar_err_reg;
    logic                        ar_hs, r_hs, rd_ok, rd_err, rd_fixed;
    logic [IDX_W-1:0]            rd_idx;

    assign aw_hs       = S_AXI_AWVALID && awready_reg;
    assign w_hs        = S_AXI_WVALID && (w_state_reg == W_DATA);
    assign w_last_beat = (w_cnt_reg == aw_len_reg);
    assign wr_ok       = in_range(aw_addr_reg);
    assign wr_idx      = word_index(aw_addr_reg);
    assign wr_en       = w_hs && wr_ok && !S_AXI_ARESET;

    // Before the AR handshake the first beat is fetched straight from the request bus.
    assign ar_hs    = S_AXI_ARVALID && arready_reg;
    assign r_hs     = rvalid_reg && S_AXI_RREADY;
    assign rd_addr  = (r_state_reg == R_IDLE) ? S_AXI_ARADDR : ar_addr_reg;
    assign rd_fixed = (r_state_reg == R_IDLE) ? fixed_burst(S_AXI_ARBURST, S_AXI_ARSIZE) : ar_fixed_reg;
    assign rd_err   = (r_state_reg == R_IDLE) ? illegal_burst(S_AXI_ARBURST, S_AXI_ARSIZE) : ar_err_reg;
    assign rd_ok    = in_range(rd_addr);
    assign rd_idx   = word_index(rd_addr);

    // One RAM per byte lane gives byte-enable writes without read-modify-write.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [C_MEM_DEPTH];
            always_ff @(posedge S_AXI_ACLK) begin
                if (wr_en && S_AXI_WSTRB[gi])
                    lane_mem[wr_idx] <= S_AXI_WDATA[gi*8 +: 8];
            end
            assign rd_word[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_reg  <= W_IDLE;
            awready_reg  <= 1'b0;
            aw_id_reg    <= '0;
            aw_addr_reg  <= '0;
            aw_len_reg   <= '0;
            aw_fixed_reg <= 1'b0;
            w_err_reg    <= 1'b0;
            w_cnt_reg    <= '0;
        end else begin
            w_state_reg <= w_state_next;
            awready_reg <= (w_state_next == W_IDLE);
            if (aw_hs) begin
                aw_id_reg    <= S_AXI_AWID;
                aw_addr_reg  <= S_AXI_AWADDR;
                aw_len_reg   <= S_AXI_AWLEN;
                aw_fixed_reg <= fixed_burst(S_AXI_AWBURST, S_AXI_AWSIZE);
                w_err_reg    <= illegal_burst(S_AXI_AWBURST, S_AXI_AWSIZE);
                w_cnt_reg    <= '0;
            end else if (w_hs) begin
                aw_addr_reg <= step_addr(aw_addr_reg, aw_fixed_reg);
                w_cnt_reg   <= w_cnt_reg + 8'd1;
                if ((S_AXI_WLAST != w_last_beat) || !wr_ok)
                    w_err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (r_hs && rlast_reg) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state_reg  <= R_IDLE;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rresp_reg    <= 2'b00;
            rid_reg      <= '0;
            rdata_reg    <= '0;
            ar_addr_reg  <= '0;
            ar_len_reg   <= '0;
            r_cnt_reg    <= '0;
            ar_fixed_reg <= 1'b0;
            ar_err_reg   <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= (r_state_next == R_IDLE);
            if (ar_hs || (r_hs && !rlast_reg)) begin
                rdata_reg   <= rd_ok ? rd_word : '0;
                rresp_reg   <= (rd_ok && !rd_err) ? 2'b00 : 2'b10;
                ar_addr_reg <= step_addr(rd_addr, rd_fixed);
            end
            if (ar_hs) begin
                rid_reg      <= S_AXI_ARID;
                ar_len_reg   <= S_AXI_ARLEN;
                ar_fixed_reg <= fixed_burst(S_AXI_ARBURST, S_AXI_ARSIZE);
                ar_err_reg   <= illegal_burst(S_AXI_ARBURST, S_AXI_ARSIZE);
                r_cnt_reg    <= '0;
                rlast_reg    <= (S_AXI_ARLEN == 8'd0);
                rvalid_reg   <= 1'b1;
            end else if (r_hs) begin
                if (rlast_reg) begin
                    rvalid_reg <= 1'b0;
                    rlast_reg  <= 1'b0;
                end else begin
                    r_cnt_reg <= r_cnt_reg + 8'd1;
                    rlast_reg <= ((r_cnt_reg + 8'd1) == ar_len_reg);
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = (w_state_reg == W_DATA);
    assign S_AXI_BVALID  = (w_state_reg == W_RESP);
    assign S_AXI_BID     = aw_id_reg;
    assign S_AXI_BRESP   = {w_err_reg, 1'b0};
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RLAST   = rlast_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RID     = rid_reg;
    assign S_AXI_RDATA   = rdata_reg;
endmodule
